// File: rtl/dense_inference_sequencer.sv
// -----------------------------------------------------------------------------
// dense_inference_sequencer
//
// Top-level controller for the dense-layer accelerator chain. A single start
// launches NUM_LAYERS dense layers back-to-back. Each layer is launched only
// after the previous layer reports done. The final layer's OUT_COUNT results
// are then read through its read port, streamed out one per strobe, and the
// argmax class is reported.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   run request, accepted in the idle state only
//   busy         out  high from the cycle after an accepted start until finish/error
//   done         out  sticky success flag, cleared by the next accepted start
//   error        out  sticky timeout flag, cleared by the next accepted start
//   layer_start  out  one-cycle launch pulse per layer
//   layer_done   in   per-layer done levels from the engines
//   rd_addr      out  read address into the final layer's result buffer
//   rd_data      in   signed read data, valid RD_LATENCY cycles after rd_addr
//   out_valid    out  one-cycle strobe per streamed result
//   out_index    out  index of the streamed result
//   out_data     out  streamed result value
//   class_idx    out  argmax index, held until the next accepted start
//   class_score  out  argmax value, held until the next accepted start
// -----------------------------------------------------------------------------
module dense_inference_sequencer #(
  parameter int unsigned NUM_LAYERS     = 2,
  parameter int unsigned OUT_COUNT      = 9,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  out_valid,
  output logic [ADDR_W-1:0]     out_index,
  output logic [DATA_W-1:0]     out_data,
  output logic [ADDR_W-1:0]     class_idx,
  output logic [DATA_W-1:0]     class_score
);

  localparam int unsigned LayerW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned TimeW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LatW   = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

  localparam logic [LayerW-1:0] LastLayer = LayerW'(NUM_LAYERS - 1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(OUT_COUNT - 1);
  localparam logic [TimeW-1:0]  TimeLast  = TimeW'(TIMEOUT_CYCLES - 1);
  localparam logic [LatW-1:0]   LatLast   = LatW'(RD_LATENCY);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StRead,
    StFinish,
    StError
  } state_e;

  state_e                  state_q, state_d;
  logic [LayerW-1:0]       layer_q, layer_d;
  logic [TimeW-1:0]        tcnt_q, tcnt_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [NUM_LAYERS-1:0]   ld_q;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]       out_index_q, out_index_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [ADDR_W-1:0]       best_idx_q, best_idx_d;
  logic [DATA_W-1:0]       best_val_q, best_val_d;
  logic [ADDR_W-1:0]       class_idx_q, class_idx_d;
  logic [DATA_W-1:0]       class_score_q, class_score_d;

  logic edge_hit;
  logic take_best;

  // Only a fresh rise of the current layer's done counts; a level that was
  // already high at launch shows up as high in ld_q and is ignored.
  assign edge_hit = layer_done[layer_q] & ~ld_q[layer_q];

  // Element 0 seeds the running best; later elements win only when strictly
  // greater, so ties keep the lowest index.
  assign take_best = (rd_addr_q == '0) || ($signed(rd_data) > $signed(best_val_q));

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    tcnt_d        = tcnt_q;
    lat_d         = lat_q;
    rd_addr_d     = rd_addr_q;
    done_d        = done_q;
    error_d       = error_q;
    out_valid_d   = 1'b0;
    out_index_d   = out_index_q;
    out_data_d    = out_data_q;
    best_idx_d    = best_idx_q;
    best_val_d    = best_val_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    layer_start   = '0;
    busy          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StLaunch;
          layer_d       = '0;
          tcnt_d        = '0;
          lat_d         = '0;
          rd_addr_d     = '0;
          done_d        = 1'b0;
          error_d       = 1'b0;
          best_idx_d    = '0;
          best_val_d    = '0;
          class_idx_d   = '0;
          class_score_d = '0;
        end
      end

      StLaunch: begin
        busy                 = 1'b1;
        layer_start[layer_q] = 1'b1;
        tcnt_d               = '0;
        state_d              = StWait;
      end

      StWait: begin
        busy = 1'b1;
        if (edge_hit) begin
          if (layer_q == LastLayer) begin
            rd_addr_d = '0;
            lat_d     = '0;
            state_d   = StRead;
          end else begin
            layer_d = layer_q + 1'b1;
            state_d = StLaunch;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TimeLast)) begin
          error_d = 1'b1;
          state_d = StError;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      StRead: begin
        busy = 1'b1;
        if (lat_q == LatLast) begin
          // rd_data now reflects rd_addr_q: stream it and fold it into argmax.
          out_valid_d = 1'b1;
          out_index_d = rd_addr_q;
          out_data_d  = rd_data;
          lat_d       = '0;
          if (take_best) begin
            best_idx_d = rd_addr_q;
            best_val_d = rd_data;
          end
          if (rd_addr_q == LastAddr) begin
            done_d        = 1'b1;
            class_idx_d   = take_best ? rd_addr_q : best_idx_q;
            class_score_d = take_best ? rd_data : best_val_q;
            state_d       = StFinish;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      StFinish: state_d = StIdle;

      StError: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      layer_q       <= '0;
      tcnt_q        <= '0;
      lat_q         <= '0;
      ld_q          <= '0;
      rd_addr_q     <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_index_q   <= '0;
      out_data_q    <= '0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      tcnt_q        <= tcnt_d;
      lat_q         <= lat_d;
      ld_q          <= layer_done;
      rd_addr_q     <= rd_addr_d;
      done_q        <= done_d;
      error_q       <= error_d;
      out_valid_q   <= out_valid_d;
      out_index_q   <= out_index_d;
      out_data_q    <= out_data_d;
      best_idx_q    <= best_idx_d;
      best_val_q    <= best_val_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
    end
  end

  assign done        = done_q;
  assign error       = error_q;
  assign rd_addr     = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign out_data    = out_data_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;

endmodule
